// File: rtl/shift_reg_ctrl_32bit.sv
// Load-then-shift sequencer for the 32-bit 74LS194 chain: one parallel load followed by N single-bit shifts.
// Optional SHIFT_CTRL_ROTATE_EN: the departing bit re-enters at the vacated end, and the fill port is ignored.
module shift_reg_ctrl_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_data,
    input  logic [CNT_W-1:0] start_cnt,
    input  logic             start_dir,
    input  logic             fill,
    input  logic             abort,
    input  logic [WIDTH-1:0] Q,
    output logic             S1,
    output logic             S0,
    output logic             SL,
    output logic             SR,
    output logic [WIDTH-1:0] PData,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counts beyond the register width would only shift in fill bits, so clamp them.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] cnt);
        if (cnt > MAX_CNT) begin
            return MAX_CNT;
        end else begin
            return cnt;
        end
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             busy_q, busy_d;
    logic             ser_valid_q, ser_valid_d;
    logic             done_q, done_d;

    logic             accept_s;
    logic             depart_s;
    logic             fill_bit_s;

    assign accept_s = start_valid & start_ready;

    // Next-state and job-capture logic; mode outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    data_d  = start_data;
                    cnt_d   = sat_cnt(start_cnt);
                    dir_d   = start_dir;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_q != '0) begin
                    rem_d   = cnt_q;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                rem_d = rem_q - CNT_W'(1);
                if ((rem_q == CNT_W'(1)) || abort) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mode_d      = MODE_HOLD;
        pdata_d     = '0;
        busy_d      = (state_d != ST_IDLE);
        ser_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            ST_LOAD: begin
                mode_d  = MODE_LOAD;
                pdata_d = data_d;
            end
            ST_SHIFT: begin
                mode_d      = dir_d ? MODE_LEFT : MODE_RIGHT;
                ser_valid_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                mode_d = MODE_HOLD;
            end
        endcase
    end

    // State, job and output registers, cleared together with the downstream register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            rem_q       <= '0;
            mode_q      <= MODE_HOLD;
            pdata_q     <= '0;
            busy_q      <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            pdata_q     <= pdata_d;
            busy_q      <= busy_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
        end
    end

    // The bit about to fall off the end the register is shifting towards.
    assign depart_s = dir_q ? Q[WIDTH-1] : Q[0];

`ifdef SHIFT_CTRL_ROTATE_EN
    logic unused_fill_s;
    assign unused_fill_s = fill;
    assign fill_bit_s    = depart_s;
`else
    assign fill_bit_s    = fill;
`endif

    assign start_ready = (state_q == ST_IDLE) & ~clear;
    assign S1          = mode_q[1];
    assign S0          = mode_q[0];
    assign SR          = ser_valid_q & ~dir_q & fill_bit_s;
    assign SL          = ser_valid_q &  dir_q & fill_bit_s;
    assign PData       = pdata_q;
    assign ser_valid   = ser_valid_q;
    assign ser_out     = ser_valid_q & depart_s;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = done_q ? Q : '0;

endmodule

// File: tb/tb_shift_reg_ctrl_32bit.sv
// Directed bench for shift_reg_ctrl_32bit, driving a behavioural 74LS194-chain model for the Q feedback.
module tb_shift_reg_ctrl_32bit;

`ifdef SHIFT_CTRL_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clear, start_valid, start_ready, start_dir, fill, abort;
    logic [31:0] start_data;
    logic [5:0]  start_cnt;
    logic [31:0] q_s, PData, result;
    logic        S1, S0, SL, SR, ser_out, ser_valid, busy, done;

    always #5 clk = ~clk;

    shift_reg_ctrl_32bit dut (
        .clk(clk), .clear(clear),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_data(start_data), .start_cnt(start_cnt), .start_dir(start_dir),
        .fill(fill), .abort(abort), .Q(q_s),
        .S1(S1), .S0(S0), .SL(SL), .SR(SR), .PData(PData),
        .ser_out(ser_out), .ser_valid(ser_valid),
        .busy(busy), .done(done), .result(result)
    );

    // Downstream register model
    always_ff @(posedge clk) begin
        if (clear) q_s <= 32'h0;
        else begin
            case ({S1, S0})
                2'b01:   q_s <= {SR, q_s[31:1]};
                2'b10:   q_s <= {q_s[30:0], SL};
                2'b11:   q_s <= PData;
                default: q_s <= q_s;
            endcase
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [5:0]  cnt;
        logic        dir;
        logic        fill;
        int          exp_lat;
        int          exp_nser;
        logic [31:0] exp_ser;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[7];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_job(input vec_t v, input int abort_at, output int lat, output int nser,
                           output logic [31:0] serv, output logic [31:0] res);
        int waited;
        waited      = 0;
        start_data  = v.data;
        start_cnt   = v.cnt;
        start_dir   = v.dir;
        fill        = v.fill;
        start_valid = 1'b1;
        while (!start_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat  = 0;
        nser = 0;
        serv = 32'h0;
        res  = 32'h0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 1) begin
                chk("load_mode", {30'd0, S1, S0}, 32'd3);
                chk("load_pdata", PData, v.data);
            end
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            if (ser_valid) begin
                if (nser < 32) serv[nser] = ser_out;
                nser++;
            end
            abort = (c == abort_at);
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, nser, ndone;
        logic [31:0] serv, res;
        vec_t        v;

        vecs[0] = '{32'h8000_0001, 6'd4,  1'b0, 1'b0, 6,  4,  32'h0000_0001, ROT ? 32'h1800_0000 : 32'h0800_0000};
        vecs[1] = '{32'h0000_00F0, 6'd8,  1'b1, 1'b1, 10, 8,  32'h0000_0000, ROT ? 32'h0000_F000 : 32'h0000_F0FF};
        vecs[2] = '{32'hDEAD_BEEF, 6'd0,  1'b0, 1'b0, 2,  0,  32'h0000_0000, 32'hDEAD_BEEF};
        vecs[3] = '{32'hA5A5_A5A5, 6'd63, 1'b0, 1'b0, 34, 32, 32'hA5A5_A5A5, ROT ? 32'hA5A5_A5A5 : 32'h0000_0000};
        vecs[4] = '{32'h1234_5678, 6'd32, 1'b1, 1'b1, 34, 32, 32'h1E6A_2C48, ROT ? 32'h1234_5678 : 32'hFFFF_FFFF};
        vecs[5] = '{32'h1234_5678, 6'd8,  1'b0, 1'b1, 10, 8,  32'h0000_0078, ROT ? 32'h7812_3456 : 32'hFF12_3456};
        vecs[6] = '{32'h1234_5678, 6'd32, 1'b0, 1'b0, 34, 32, 32'h1234_5678, ROT ? 32'h1234_5678 : 32'h0000_0000};

        clear = 1'b1; start_valid = 1'b0; start_data = 32'h0; start_cnt = 6'd0;
        start_dir = 1'b0; fill = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {24'd0, busy, done, ser_valid, S1, S0, SL, SR, start_ready}, 32'h0);
        chk("rst_pdata", PData, 32'h0);
        chk("rst_result", result, 32'h0);
        clear = 1'b0;
        #1;
        chk("rst_ready", {31'd0, start_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i], -1, lat, nser, serv, res);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_nser", i), nser, vecs[i].exp_nser);
            chk($sformatf("v%0d_serbits", i), serv, vecs[i].exp_ser);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp_res);
        end

        // Abort in the third shift cycle (cycles 2..4 after accept are SHIFT)
        v = '{32'hFFFF_FFFF, 6'd20, 1'b0, 1'b0, 5, 3, 32'h7, ROT ? 32'hFFFF_FFFF : 32'h1FFF_FFFF};
        run_job(v, 4, lat, nser, serv, res);
        chk("abort_latency", lat, v.exp_lat);
        chk("abort_nser", nser, v.exp_nser);
        chk("abort_serbits", serv, v.exp_ser);
        chk("abort_result", res, v.exp_res);

        // Clear held two cycles in the middle of a shift job
        @(posedge clk); #1;
        start_data = 32'h0F0F_0F0F; start_cnt = 6'd20; start_dir = 1'b0; fill = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("clr_pre_busy", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        ndone = 0;
        @(posedge clk); #1;
        chk("clr_ctrl", {26'd0, busy, done, ser_valid, S1, S0, start_ready}, 32'h0);
        chk("clr_pdata", PData, 32'h0);
        @(posedge clk); #1;
        chk("clr_q", q_s, 32'h0);
        chk("clr_busy2", {31'd0, busy}, 32'd0);
        clear = 1'b0;
        #1;
        chk("clr_ready", {31'd0, start_ready}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("clr_no_done", ndone, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
